// File: rtl/bp_pkg.sv
// Shared encodings and the saturating-counter update used by the branch predictor.
package bp_pkg;

   localparam logic [1:0]  SNT    = 2'b00;
   localparam logic [1:0]  WNT    = 2'b01;
   localparam logic [1:0]  WT     = 2'b10;
   localparam logic [1:0]  ST     = 2'b11;
   localparam logic [31:0] PC_INC = 32'd4;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
      else       return (cnt == SNT) ? SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> predictor signal bundle. Optional statistics outputs exist only
// when BP_STATS_EN is defined.
interface branch_predictor_if;

   logic        is_branch_ID;
   logic [31:0] pc_ID;
   logic        stall_ID_EX;
   logic        flush_ID_EX;
   logic        br_valid_EX;
   logic        br_taken_EX;
   logic [31:0] br_target_EX;
   logic        B_jump;
   logic        Flush_B;
   logic [31:0] br_pc;
`ifdef BP_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] mis_cnt;
`endif

   modport master (
      output is_branch_ID, pc_ID, stall_ID_EX, flush_ID_EX,
      output br_valid_EX, br_taken_EX, br_target_EX,
`ifdef BP_STATS_EN
      input  br_cnt, mis_cnt,
`endif
      input  B_jump, Flush_B, br_pc
   );

   modport slave (
      input  is_branch_ID, pc_ID, stall_ID_EX, flush_ID_EX,
      input  br_valid_EX, br_taken_EX, br_target_EX,
`ifdef BP_STATS_EN
      output br_cnt, mis_cnt,
`endif
      output B_jump, Flush_B, br_pc
   );

endinterface

// File: rtl/bht_table.sv
// Branch history table: 2-bit saturating counters, async read, sync trained write.
module bht_table
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W    = 6,
   parameter logic [1:0]  CNT_INIT = WNT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx_r,
   output logic [1:0]       cnt_r,
   input  logic             we,
   input  logic [IDX_W-1:0] idx_w,
   input  logic             taken
);

   logic [1:0] bht_q [2**IDX_W];

   // Read returns the pre-update value when read and write hit the same entry.
   assign cnt_r = bht_q[idx_r];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**IDX_W; i++) bht_q[i] <= CNT_INIT;
      end else if (we) begin
         bht_q[idx_w] <= sat_update(bht_q[idx_w], taken);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: ID lookup, ID->EX prediction tracking, EX resolve/train.
// Define BP_STATS_EN to add the br_cnt / mis_cnt statistics counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W    = 6,
   parameter logic [1:0]  CNT_INIT = WNT
) (
   input logic               clk,
   input logic               rst_n,
   branch_predictor_if.slave bus
);

   logic [IDX_W-1:0] lk_idx;
   logic [1:0]       lk_cnt;
   logic             trk_valid_q;
   logic             trk_pred_q;
   logic [31:0]      trk_pc_q;
   logic             train;
   logic             mis;

   assign lk_idx = bus.pc_ID[IDX_W+1:2];

   bht_table #(
      .IDX_W    (IDX_W),
      .CNT_INIT (CNT_INIT)
   ) u_bht (
      .clk   (clk),
      .rst_n (rst_n),
      .idx_r (lk_idx),
      .cnt_r (lk_cnt),
      .we    (train),
      .idx_w (trk_pc_q[IDX_W+1:2]),
      .taken (bus.br_taken_EX)
   );

   assign bus.B_jump = bus.is_branch_ID & lk_cnt[1];

   // Flush beats stall; a flushed slot keeps stale pred/pc but is marked invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_valid_q <= 1'b0;
         trk_pred_q  <= 1'b0;
         trk_pc_q    <= 32'd0;
      end else if (bus.flush_ID_EX) begin
         trk_valid_q <= 1'b0;
      end else if (!bus.stall_ID_EX) begin
         trk_valid_q <= bus.is_branch_ID;
         trk_pred_q  <= bus.B_jump;
         trk_pc_q    <= bus.pc_ID;
      end
   end

   always_comb begin
      train       = bus.br_valid_EX & trk_valid_q;
      mis         = train & (bus.br_taken_EX != trk_pred_q);
      bus.Flush_B = mis;
      bus.br_pc   = 32'd0;
      if (mis) bus.br_pc = bus.br_taken_EX ? bus.br_target_EX : trk_pc_q + PC_INC;
   end

`ifdef BP_STATS_EN
   logic [31:0] br_cnt_q;
   logic [31:0] mis_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q  <= 32'd0;
         mis_cnt_q <= 32'd0;
      end else if (!(bus.stall_ID_EX && !bus.br_valid_EX)) begin
         if (train) br_cnt_q  <= br_cnt_q + 32'd1;
         if (mis)   mis_cnt_q <= mis_cnt_q + 32'd1;
      end
   end

   assign bus.br_cnt  = br_cnt_q;
   assign bus.mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// compared each cycle against a behavioural model.
module tb_branch_predictor;

   localparam int NENT = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_predictor_if bus ();

   branch_predictor #(
      .IDX_W    (6),
      .CNT_INIT (2'b01)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   // Behavioural model state
   int          m_bht [NENT];
   bit          m_trk_valid;
   bit          m_trk_pred;
   logic [31:0] m_trk_pc;
   logic [31:0] m_br_cnt;
   logic [31:0] m_mis_cnt;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % NENT);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) m_bht[i] = 1;
      m_trk_valid = 0;
      m_trk_pred  = 0;
      m_trk_pc    = 32'd0;
      m_br_cnt    = 32'd0;
      m_mis_cnt   = 32'd0;
   endtask

   function automatic bit exp_bjump();
      return bus.is_branch_ID && (m_bht[idx_of(bus.pc_ID)] >= 2);
   endfunction

   function automatic bit exp_mis();
      return bus.br_valid_EX && m_trk_valid && (bus.br_taken_EX != m_trk_pred);
   endfunction

   function automatic logic [31:0] exp_brpc();
      if (!exp_mis()) return 32'd0;
      return bus.br_taken_EX ? bus.br_target_EX : m_trk_pc + 32'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input bit rst, input bit isb, input logic [31:0] pc, input bit stall,
                        input bit flush, input bit bv, input bit bt, input logic [31:0] tgt);
      @(negedge clk);
      rst_n            = rst;
      bus.is_branch_ID = isb;
      bus.pc_ID        = pc;
      bus.stall_ID_EX  = stall;
      bus.flush_ID_EX  = flush;
      bus.br_valid_EX  = bv;
      bus.br_taken_EX  = bt;
      bus.br_target_EX = tgt;
      if (!rst) model_reset();
      #1;
   endtask

   task automatic check_model();
      chk("B_jump", {31'd0, bus.B_jump}, {31'd0, exp_bjump()});
      chk("Flush_B", {31'd0, bus.Flush_B}, {31'd0, exp_mis()});
      chk("br_pc", bus.br_pc, exp_brpc());
`ifdef BP_STATS_EN
      chk("br_cnt", bus.br_cnt, m_br_cnt);
      chk("mis_cnt", bus.mis_cnt, m_mis_cnt);
`endif
   endtask

   // Apply the effect of the coming clock edge to the model.
   task automatic model_advance();
      bit train, mis, bj;
      int ti;
      if (!rst_n) return;
      bj    = exp_bjump();
      mis   = exp_mis();
      train = bus.br_valid_EX && m_trk_valid;
      if (train) begin
         ti = idx_of(m_trk_pc);
         if (bus.br_taken_EX) m_bht[ti] = (m_bht[ti] == 3) ? 3 : m_bht[ti] + 1;
         else                 m_bht[ti] = (m_bht[ti] == 0) ? 0 : m_bht[ti] - 1;
      end
      if (!(bus.stall_ID_EX && !bus.br_valid_EX)) begin
         if (train) m_br_cnt++;
         if (mis)   m_mis_cnt++;
      end
      if (bus.flush_ID_EX) begin
         m_trk_valid = 0;
      end else if (!bus.stall_ID_EX) begin
         m_trk_valid = bus.is_branch_ID;
         m_trk_pred  = bj;
         m_trk_pc    = bus.pc_ID;
      end
   endtask

   task automatic step(input bit isb, input logic [31:0] pc, input bit stall, input bit flush,
                       input bit bv, input bit bt, input logic [31:0] tgt);
      drive(1'b1, isb, pc, stall, flush, bv, bt, tgt);
      check_model();
      model_advance();
   endtask

   initial begin
      logic [31:0] pool [6];
      pool = '{32'h100, 32'h104, 32'h14, 32'h200, 32'hFFFF_FFFC, 32'h0};
      model_reset();

      // Reset state
      drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h140);
      chk("reset_Flush_B", {31'd0, bus.Flush_B}, 32'd0);
      chk("reset_br_pc", bus.br_pc, 32'd0);
      chk("reset_B_jump", {31'd0, bus.B_jump}, 32'd0);
      check_model();

      // Cold branch at 0x100: predicted not-taken
      drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("cold_B_jump", {31'd0, bus.B_jump}, 32'd0);
      check_model(); model_advance();
      // Resolves taken -> mispredict to target
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h140);
      chk("mis1_Flush_B", {31'd0, bus.Flush_B}, 32'd1);
      chk("mis1_br_pc", bus.br_pc, 32'h140);
      check_model(); model_advance();
      chk("cnt_01_to_10", m_bht[0], 2);
      drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("warm_B_jump", {31'd0, bus.B_jump}, 32'd1);
      check_model(); model_advance();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h140);
      chk("hit_Flush_B", {31'd0, bus.Flush_B}, 32'd0);
      chk("hit_br_pc", bus.br_pc, 32'd0);
      check_model(); model_advance();
      chk("cnt_10_to_11", m_bht[0], 3);

      // Strongly taken, resolves not-taken at 0x200 (same index)
      step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h999);
      chk("nt_Flush_B", {31'd0, bus.Flush_B}, 32'd1);
      chk("nt_br_pc", bus.br_pc, 32'h204);
      check_model(); model_advance();
      chk("cnt_11_to_10", m_bht[0], 2);

      // Saturation high and low, correct predictions never flush
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h140);
         chk("sat_hi_no_flush", {31'd0, bus.Flush_B}, 32'd0);
         check_model(); model_advance();
      end
      chk("sat_hi_cnt", m_bht[0], 3);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         chk("sat_lo_no_flush", {31'd0, bus.Flush_B}, 32'd0);
         check_model(); model_advance();
      end
      chk("sat_lo_cnt", m_bht[1], 0);

      // Same-cycle lookup and training of index 5: read-before-write
      step(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
      chk("rbw_old_B_jump", {31'd0, bus.B_jump}, 32'd0);
      check_model(); model_advance();
      drive(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rbw_new_B_jump", {31'd0, bus.B_jump}, 32'd1);
      check_model(); model_advance();

      // Flush beats stall; stray br_valid with empty tracker does nothing
      step(1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("bubble_Flush_B", {31'd0, bus.Flush_B}, 32'd0);
      check_model(); model_advance();
      drive(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("bubble_no_train", {31'd0, bus.B_jump}, 32'd1);
      check_model(); model_advance();

      // Mid-sequence reset returns every counter to weakly not-taken
      drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("midrst_Flush_B", {31'd0, bus.Flush_B}, 32'd0);
      check_model();
      drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("midrst_B_jump", {31'd0, bus.B_jump}, 32'd0);
      check_model(); model_advance();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit          r, isb, st, fl, bv, bt;
         logic [31:0] pc;
         r   = ($urandom_range(0, 299) != 0);
         isb = ($urandom_range(0, 3) != 0);
         pc  = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 5)];
         st  = ($urandom_range(0, 9) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         bv  = ($urandom_range(0, 1) == 1);
         bt  = ($urandom_range(0, 2) != 0);
         drive(r, isb, pc, st, fl, bv, bt, $urandom);
         check_model();
         model_advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
